// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, branch-condition codes, fetch states and flag bit
// positions shared by the fetch stage and the later pipeline stages.
package cpu_pkg;

  // Opcode field values (instr[INSTR_W-1 -: 4]).
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Branch condition field (ccc) encodings.
  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HALT
  } fetch_state_e;

  // Bit positions inside the {Z,V,N} flag vector.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // True for opcodes that alter control flow or stop the machine.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op == OP_B) || (op == OP_BR) || (op == OP_PCS) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: purely combinational ccc x {Z,V,N} -> taken decision.
// Shared between the fetch redirect and the BR forwarding path.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  // Decode the condition field against the current flags.
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:     taken = ~z;
      CC_EQ:     taken = z;
      CC_GT:     taken = ~z & ~n;
      CC_LT:     taken = n;
      CC_GE:     taken = z | (~z & ~n);
      CC_LE:     taken = n | z;
      CC_OVFL:   taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, runs a request/ready
// handshake to instruction memory, redirects on taken branches (squashing
// any in-flight response), halts on HLT and drives the IF/ID latch with a
// one-entry skid buffer for responses that arrive while stalled.
// Optional build macro FETCH_PERF_EN adds saturating perf counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                IMM_W    = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               imem_ready_i,
  input  logic               br_en_i,
  input  logic               br_reg_i,
  input  logic [2:0]         br_cond_i,
  input  logic [2:0]         flags_i,
  input  logic [IMM_W-1:0]   br_imm_i,
  input  logic [ADDR_W-1:0]  br_pc2_i,
  input  logic [ADDR_W-1:0]  br_rs_i,
  output logic               br_taken_o,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc2_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               hlt_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched_o,
  output logic [31:0]        perf_stall_o
`endif
);

  fetch_state_e       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic               squash_reg, squash_next;
  logic               skid_valid_reg, skid_valid_next;
  logic [INSTR_W-1:0] skid_instr_reg, skid_instr_next;
  logic               if_valid_reg, if_valid_next;
  logic [INSTR_W-1:0] if_instr_reg, if_instr_next;
  logic [ADDR_W-1:0]  if_pc2_reg, if_pc2_next;
  logic               hlt_reg, hlt_next;

  logic               req;
  logic               resp;
  logic               cond_true;
  logic               taken;
  logic               load;
  logic [INSTR_W-1:0] load_instr;
  logic [ADDR_W-1:0]  pc_plus2;
  logic [ADDR_W-1:0]  imm_sext;
  logic [ADDR_W-1:0]  br_target;

  branch_cond_eval u_cond (
    .cond  (br_cond_i),
    .flags (flags_i),
    .taken (cond_true)
  );

  // A full skid means a response is already held, so no new request.
  assign req       = (state_reg == REQ) && !skid_valid_reg;
  // A response for a squashed request is consumed but never used.
  assign resp      = req && imem_ready_i && !squash_reg;
  assign taken     = br_en_i & cond_true & ~stall_i;
  assign pc_plus2  = pc_reg + ADDR_W'(2);
  assign imm_sext  = {{(ADDR_W-IMM_W){br_imm_i[IMM_W-1]}}, br_imm_i};
  assign br_target = br_reg_i ? br_rs_i
                              : br_pc2_i + {imm_sext[ADDR_W-2:0], 1'b0};

  // Next-state: redirect wins over everything, else sequence the fetch.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    squash_next     = squash_reg;
    skid_valid_next = skid_valid_reg;
    skid_instr_next = skid_instr_reg;
    if_valid_next   = if_valid_reg;
    if_instr_next   = if_instr_reg;
    if_pc2_next     = if_pc2_reg;
    hlt_next        = hlt_reg;
    load            = 1'b0;
    load_instr      = skid_instr_reg;

    if (taken) begin
      pc_next         = br_target;
      if_valid_next   = 1'b0;
      skid_valid_next = 1'b0;
      hlt_next        = 1'b0;
      state_next      = REQ;
      // Still waiting on memory: its eventual response must be dropped.
      squash_next     = req && !imem_ready_i;
    end else begin
      case (state_reg)
        IDLE: state_next = REQ;
        REQ: begin
          if (req && imem_ready_i) begin
            squash_next = 1'b0;
          end
          if (stall_i) begin
            if (resp) begin
              skid_valid_next = 1'b1;
              skid_instr_next = imem_rdata_i;
            end
          end else if (skid_valid_reg) begin
            load            = 1'b1;
            load_instr      = skid_instr_reg;
            skid_valid_next = 1'b0;
          end else if (resp) begin
            load       = 1'b1;
            load_instr = imem_rdata_i;
          end else begin
            if_valid_next = 1'b0;
          end
          if (load) begin
            if_valid_next = 1'b1;
            if_instr_next = load_instr;
            if_pc2_next   = pc_plus2;
            pc_next       = pc_plus2;
            if (load_instr[INSTR_W-1 -: 4] == OP_HLT) begin
              hlt_next   = 1'b1;
              state_next = HALT;
            end
          end
        end
        HALT: begin
          if (!stall_i) begin
            if_valid_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      squash_reg     <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= '0;
      if_valid_reg   <= 1'b0;
      if_instr_reg   <= '0;
      if_pc2_reg     <= '0;
      hlt_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      squash_reg     <= squash_next;
      skid_valid_reg <= skid_valid_next;
      skid_instr_reg <= skid_instr_next;
      if_valid_reg   <= if_valid_next;
      if_instr_reg   <= if_instr_next;
      if_pc2_reg     <= if_pc2_next;
      hlt_reg        <= hlt_next;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_reg;
  assign br_taken_o  = taken;
  assign if_valid_o  = if_valid_reg;
  assign if_instr_o  = if_instr_reg;
  assign if_pc2_o    = if_pc2_reg;
  assign pc_o        = pc_reg;
  assign hlt_o       = hlt_reg;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  // Saturating counts of IF/ID loads and memory wait cycles, frozen in HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
    end else if (state_reg != HALT) begin
      if (load && (perf_fetched_reg != 32'hFFFF_FFFF)) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (req && !imem_ready_i && (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_reg;
  assign perf_stall_o   = perf_stall_reg;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the next-generation pipelined CPU. It owns the PC register and talks to a variable-latency instruction memory through a request/ready handshake. It evaluates B/BR conditions against the flag register and redirects fetch on a taken branch. It detects HLT, freezes fetch, and drives the IF/ID latch outputs with stall and flush support.

Parameters:
ADDR_W, 16, PC and instruction-memory address width
INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4]
IMM_W, 9, B-format signed offset width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_i  in  1  hazard unit holds IF/ID; PC and outputs frozen
imem_req_o  out  1  instruction-memory request valid
imem_addr_o  out  ADDR_W  request address (= pc_o)
imem_rdata_i  in  INSTR_W  returned instruction
imem_ready_i  in  1  rdata valid for the outstanding request this cycle
br_en_i  in  1  ID holds a B or BR instruction
br_reg_i  in  1  1 = BR (target from rs), 0 = B (PC-relative)
br_cond_i  in  3  ccc condition field
flags_i  in  3  {Z,V,N}
br_imm_i  in  IMM_W  signed offset from the B instruction
br_pc2_i  in  ADDR_W  PC+2 of the branch instruction
br_rs_i  in  ADDR_W  rs contents for BR
br_taken_o  out  1  combinational: branch in ID is taken
if_valid_o  out  1  IF/ID holds a valid instruction
if_instr_o  out  INSTR_W  fetched instruction
if_pc2_o  out  ADDR_W  PC+2 of the fetched instruction
pc_o  out  ADDR_W  current fetch PC
hlt_o  out  1  HLT fetched; fetch frozen

Behaviour:
- Reset (rst=1 at posedge): pc_o=RESET_PC, if_valid_o=0, if_instr_o=0, if_pc2_o=0, hlt_o=0, imem_req_o=0, squash=0, skid empty, state=IDLE. Reset mid-request discards any later imem_ready_i.
- States: IDLE, REQ, HALT.
- IDLE: cycle after reset; goes to REQ with imem_req_o=1.
- REQ: imem_req_o=1, imem_addr_o=pc_o held stable until imem_ready_i. Minimum latency is one cycle: ready can arrive in the same cycle as the request.
- On ready with no squash:
  - stall_i=0: IF/ID loads instr and pc+2, if_valid_o=1, pc<=pc+2 (mod 2^ADDR_W, 0xFFFE wraps to 0x0000), new request issued the next cycle.
  - stall_i=1: the response goes into a one-entry skid buffer and no new request is issued. The skid drains into IF/ID on the first cycle with stall_i=0.
- Ready cycle with no ready and stall_i=0: if_valid_o=0 (bubble).
- Branch taken: br_taken_o = br_en_i & cond & ~stall_i.
  - cond by ccc: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
  - Target: BR -> br_rs_i; B -> br_pc2_i + (sext(br_imm_i)<<1), truncated to ADDR_W.
  - Taken cycle: pc<=target, if_valid_o<=0 (flush), skid cleared, state<=REQ.
  - A request still outstanding gets squash=1. Its response is dropped and the target is requested after that response.
  - Taken branch overrides stall, HLT and skid contents.
- HLT: instruction with opcode 4'hF loaded into IF/ID -> hlt_o=1 next cycle, state=HALT, imem_req_o=0. pc_o stays at HLT address+2 and is not advanced.
- HALT: a taken branch from an older instruction exits to REQ with hlt_o=0. Otherwise stays until rst.
- br_en_i ignored while stall_i=1.

Optional Feature:
FETCH_PERF_EN. When defined, adds outputs perf_fetched_o[31:0] (counts IF/ID loads) and perf_stall_o[31:0] (counts cycles with imem_req_o=1 and imem_ready_i=0). Both are saturating, reset to 0 and frozen in HALT. When undefined, these ports and their logic are absent and the rest of the block is identical.

Decomposition:
- cpu_pkg holds:
  - opcode constants (OP_B=4'hC, OP_BR=4'hD, OP_PCS=4'hE, OP_HLT=4'hF)
  - branch-condition localparams CC_NE through CC_UNCOND
  - fetch state enum {IDLE, REQ, HALT}
  - flag bit indices FLAG_Z, FLAG_V, FLAG_N
- One sub-module, branch_cond_eval: purely combinational ccc x flags -> taken, shared with the later BR forwarding path.

Test Plan:
- Reset, then ready every cycle, imem returns 0x1234, 0x5678 -> req addrs 0x0000, 0x0002; if_valid_o=1; if_pc2_o 0x0002, 0x0004; pc_o 0x0004.
- imem_ready_i delayed 3 cycles at pc 0x0010 -> imem_addr_o holds 0x0010 for 4 cycles, if_valid_o=0 for 3 cycles, then the instruction loads.
- B ccc=001, Z=1, br_pc2_i=0x0020, br_imm_i=0x1FE (-2) -> target 0x001C; next if_valid_o=0; next request addr 0x001C.
- Taken BR rs=0x0100 while a request to 0x0006 is outstanding -> late response dropped; next request 0x0100; first valid instr comes from 0x0100.
- Fetch 0xF000 at 0x0008 -> hlt_o=1, imem_req_o=0 for 10 cycles. Then an older taken branch to 0x0040 -> hlt_o=0, request 0x0040.
- stall_i=1 for 2 cycles while a response arrives -> IF/ID unchanged; skid drains on the first cycle stall_i=0; no instruction lost or duplicated.
